// File: rtl/fp_square_if.sv
// fp_square go/done handshake bundle.
// FP_SQUARE_SATURATE_EN adds the registered overflow flag.
interface fp_square_if #(
  parameter int WIDTH = 32
);
  logic             go;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             done;
`ifdef FP_SQUARE_SATURATE_EN
  logic             overflow;
`endif

  modport master (
    output go, in,
`ifdef FP_SQUARE_SATURATE_EN
    input  overflow,
`endif
    input  out, done
  );

  modport slave (
    input  go, in,
`ifdef FP_SQUARE_SATURATE_EN
    output overflow,
`endif
    output out, done
  );
endinterface

// File: rtl/fp_square.sv
// fp_square: multi-cycle unsigned fixed-point squarer.
// out = (in*in) >> FRAC_WIDTH, one shift-and-add step per cycle, WIDTH cycles
// from the capture edge to the done pulse.
// FP_SQUARE_SATURATE_EN: clamp out to all ones on overflow and raise overflow
// with done; otherwise the result wraps modulo 2^WIDTH.
module fp_square #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input logic        clk,
  input logic        reset,
  fp_square_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  // Reject inconsistent fixed-point formats at elaboration.
  generate
    if (INT_WIDTH + FRAC_WIDTH != WIDTH || FRAC_WIDTH < 0 || FRAC_WIDTH >= WIDTH) begin : g_cfg_err
      $error("fp_square: INT_WIDTH + FRAC_WIDTH must equal WIDTH, 0 <= FRAC_WIDTH < WIDTH");
    end
  endgenerate

  logic             running;
  logic [IW-1:0]    idx;
  logic [PW-1:0]    m;      // multiplicand, shifts left each step
  logic [WIDTH-1:0] q;      // multiplier, shifts right each step
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nxt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] out_r;
  logic             done_r;
`ifdef FP_SQUARE_SATURATE_EN
  logic             ovf;
  logic             ovf_r;
`endif

  // Accumulator after this cycle's conditional add; the last step's result
  // feeds the output register directly so no extra cycle is spent.
  always_comb begin
    acc_nxt = q[0] ? acc + m : acc;
`ifdef FP_SQUARE_SATURATE_EN
    ovf     = |(acc_nxt >> (WIDTH + FRAC_WIDTH));
    res     = ovf ? {WIDTH{1'b1}} : acc_nxt[FRAC_WIDTH +: WIDTH];
`else
    res     = acc_nxt[FRAC_WIDTH +: WIDTH];
`endif
  end

  // Capture on go while idle, iterate while running, load out on the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      idx     <= '0;
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      out_r   <= '0;
      done_r  <= 1'b0;
`ifdef FP_SQUARE_SATURATE_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
`ifdef FP_SQUARE_SATURATE_EN
      ovf_r  <= 1'b0;
`endif
      if (!running) begin
        if (bus.go) begin
          m       <= {{WIDTH{1'b0}}, bus.in};
          q       <= bus.in;
          acc     <= '0;
          running <= 1'b1;
          idx     <= '0;
        end
      end else begin
        acc <= acc_nxt;
        m   <= m << 1;
        q   <= q >> 1;
        idx <= idx + 1'b1;
        if (idx == IW'(WIDTH - 1)) begin
          running <= 1'b0;
          out_r   <= res;
          done_r  <= 1'b1;
`ifdef FP_SQUARE_SATURATE_EN
          ovf_r   <= ovf;
`endif
        end
      end
    end
  end

  assign bus.out  = out_r;
  assign bus.done = done_r;
`ifdef FP_SQUARE_SATURATE_EN
  assign bus.overflow = ovf_r;
`endif
endmodule

// File: doc/fp_square.md
Name: fp_square

Overview:
- Multi-cycle, unsigned fixed-point squarer; the inverse operation of the team's iterative square-root primitive.
- Computes out = (in * in) >> FRAC_WIDTH using one shift-and-add step per cycle.
- Uses the same go/done latency-insensitive interface as the other math primitives, so the compiler can schedule it as a multi-cycle component.
- Setting FRAC_WIDTH=0 gives an integer squarer.

Parameters:
- WIDTH, 32, total operand/result width in bits.
- INT_WIDTH, 16, integer bits; informational; must satisfy INT_WIDTH + FRAC_WIDTH == WIDTH.
- FRAC_WIDTH, 16, fractional bits; result scaling shift; 0 <= FRAC_WIDTH < WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- go  input  1  start request; sampled only while idle.
- in  input  WIDTH  unsigned fixed-point operand; sampled on the start edge only.
- out  output  WIDTH  result register; holds its last value until the next completion or reset.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: done=0, out=0, running=0, iteration counter=0.
- Reset takes priority over every other event.
- Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE and BUSY, held as a single running flag plus a counter idx of width $clog2(WIDTH).
- Start: if go=1 and running=0 at rising edge E0:
  - capture multiplicand M=in and multiplier Q=in;
  - clear the 2*WIDTH-bit accumulator;
  - set running=1 and idx=0.
- go while BUSY is ignored; it does not restart the operation or disturb the captured operand.
- Iteration, on each BUSY edge:
  - if Q[0]=1, add M (zero-extended to 2*WIDTH) into the accumulator;
  - shift M left by 1 and Q right by 1;
  - idx increments.
- Exactly WIDTH iterations, on edges E1..E_WIDTH.
- Finish: on the edge where idx==WIDTH-1 and running=1:
  - running clears;
  - out is loaded from the final accumulator value, including that cycle's add;
  - done=1.
- done is high for exactly one cycle, starting after edge E_WIDTH. Latency is WIDTH cycles from the capture edge.
- Result selection: full = full 2*WIDTH-bit product; out = full[FRAC_WIDTH +: WIDTH], i.e. fractional LSBs truncated (round toward zero).
- Overflow condition: any bit of full above index WIDTH+FRAC_WIDTH-1 is set.
  - Without the optional feature, out takes the truncated bits (wraps modulo 2^WIDTH).
- go=1 during the done cycle is legal: the block is IDLE, so a new operation starts on that edge.
- out keeps the previous result until the new completion.
- All arithmetic is unsigned; there are no sign semantics.

Optional Feature:
- Macro: FP_SQUARE_SATURATE_EN.
- Defined:
  - on overflow, out is loaded with all ones ({WIDTH{1'b1}});
  - an extra output port overflow (1 bit, reset 0) is registered alongside out and pulses with done when saturation occurred.
- Not defined:
  - out wraps as described in Behaviour;
  - the overflow port does not exist;
  - no saturation logic is synthesized.

Test Plan:
- WIDTH=32, FRAC_WIDTH=16: go with in=0x00030000 (3.0) -> done exactly 32 cycles after the capture edge, out=0x00090000 (9.0), done high for 1 cycle only.
- WIDTH=32, FRAC_WIDTH=16: in=0x00018000 (1.5) -> out=0x00024000 (2.25); in=0x00000001 -> out=0x00000000 (truncation).
- WIDTH=32, FRAC_WIDTH=0: back-to-back operations, in=12 then in=0xFFFF with go held through the done cycle -> out=144, then out=0xFFFE0001; second op starts on the first op's done cycle.
- WIDTH=32, FRAC_WIDTH=16: in=0x01000000 (256.0) -> without macro out=0x00000000; with FP_SQUARE_SATURATE_EN out=0xFFFFFFFF and overflow=1 with done.
- Assert reset at iteration 10 of an in=0x00050000 operation -> done never pulses, out=0, next go with in=0x00020000 yields out=0x00040000 after 32 cycles.
- Change in and pulse go mid-operation -> ignored; result still reflects the operand captured on the start edge.
